// File: rtl/food_placer_if.sv
// Signal bundle between the food placer, the LFSR, the occupancy responder and game control.
// The master side is the placer; the slave side is everything around it.
interface food_placer_if #(
    parameter int X_BITS = 5,
    parameter int Y_BITS = 5
);
    logic              rand_bit;
    logic              place_req;
    logic              query_valid;
    logic [X_BITS-1:0] query_x;
    logic [Y_BITS-1:0] query_y;
    logic              occ_valid;
    logic              occ_hit;
    logic [X_BITS-1:0] food_x;
    logic [Y_BITS-1:0] food_y;
    logic              food_valid;
    logic              place_fail;
    logic              busy;

    modport master (
        input  rand_bit, place_req, occ_valid, occ_hit,
        output query_valid, query_x, query_y, food_x, food_y, food_valid, place_fail, busy
    );

    modport slave (
        output rand_bit, place_req, occ_valid, occ_hit,
        input  query_valid, query_x, query_y, food_x, food_y, food_valid, place_fail, busy
    );
endinterface

// File: rtl/food_placer.sv
// Picks a free food cell from the LFSR stream: random candidates first, then a row-major scan.
// Query 12 cycles after place_req, food_valid 2 cycles after occ_valid; place_req ignored while busy.
module food_placer #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int X_BITS    = 5,
    parameter int Y_BITS    = 5,
    parameter int MAX_TRIES = 16
) (
    input  logic          clock,
    input  logic          reset,
    food_placer_if.master bus
);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int SCAN_W = $clog2(CELLS + 1);
    localparam int SH_MAX = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
    localparam int SH_W   = $clog2(SH_MAX + 1);

    localparam logic [X_BITS-1:0] X_LAST     = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_LAST     = Y_BITS'(GRID_H - 1);
    localparam logic [TRY_W-1:0]  TRY_LIMIT  = TRY_W'(MAX_TRIES);
    localparam logic [SCAN_W-1:0] SCAN_LIMIT = SCAN_W'(CELLS);
    localparam logic [SH_W-1:0]   X_SH_LAST  = SH_W'(X_BITS - 1);
    localparam logic [SH_W-1:0]   Y_SH_LAST  = SH_W'(Y_BITS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SHIFT_X,
        S_SHIFT_Y,
        S_RANGE,
        S_QUERY,
        S_WAIT,
        S_SCAN,
        S_DONE,
        S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [X_BITS-1:0] cand_x_q, cand_x_d;
    logic [Y_BITS-1:0] cand_y_q, cand_y_d;
    logic [X_BITS-1:0] food_x_q, food_x_d;
    logic [Y_BITS-1:0] food_y_q, food_y_d;
    logic [TRY_W-1:0]  try_cnt_q, try_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [SH_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              scan_mode_q, scan_mode_d;
    // Set on entry to scan mode so the first SCAN visit queries (0,0) without advancing.
    logic              scan_hold_q, scan_hold_d;
    logic              occ_vld_q;
    logic              occ_hit_q;

    logic              in_range;
    logic [TRY_W-1:0]  try_inc;
    logic [SCAN_W-1:0] scan_inc;

    assign in_range = (int'(cand_x_q) < GRID_W) && (int'(cand_y_q) < GRID_H);
    assign try_inc  = try_cnt_q + TRY_W'(1);
    assign scan_inc = scan_cnt_q + SCAN_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            food_x_q    <= '0;
            food_y_q    <= '0;
            try_cnt_q   <= '0;
            scan_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            scan_mode_q <= 1'b0;
            scan_hold_q <= 1'b0;
            occ_vld_q   <= 1'b0;
            occ_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            food_x_q    <= food_x_d;
            food_y_q    <= food_y_d;
            try_cnt_q   <= try_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            scan_mode_q <= scan_mode_d;
            scan_hold_q <= scan_hold_d;
            // Responses are registered; anything arriving outside WAIT is dropped here.
            occ_vld_q   <= bus.occ_valid && (state_q == S_WAIT) && !occ_vld_q;
            occ_hit_q   <= bus.occ_hit;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        food_x_d    = food_x_q;
        food_y_d    = food_y_q;
        try_cnt_d   = try_cnt_q;
        scan_cnt_d  = scan_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        scan_mode_d = scan_mode_q;
        scan_hold_d = scan_hold_q;

        case (state_q)
            S_IDLE: begin
                if (bus.place_req) begin
                    state_d     = S_SHIFT_X;
                    try_cnt_d   = '0;
                    scan_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    scan_mode_d = 1'b0;
                    scan_hold_d = 1'b0;
                end
            end
            S_SHIFT_X: begin
                cand_x_d  = {cand_x_q[X_BITS-2:0], bus.rand_bit};
                bit_cnt_d = bit_cnt_q + SH_W'(1);
                if (bit_cnt_q == X_SH_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT_Y;
                end
            end
            S_SHIFT_Y: begin
                cand_y_d  = {cand_y_q[Y_BITS-2:0], bus.rand_bit};
                bit_cnt_d = bit_cnt_q + SH_W'(1);
                if (bit_cnt_q == Y_SH_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = S_RANGE;
                end
            end
            S_RANGE: begin
                if (in_range) begin
                    state_d = S_QUERY;
                end else begin
                    try_cnt_d = try_inc;
                    if (try_inc == TRY_LIMIT) begin
                        state_d     = S_SCAN;
                        cand_x_d    = '0;
                        cand_y_d    = '0;
                        scan_mode_d = 1'b1;
                        scan_hold_d = 1'b1;
                    end else begin
                        state_d = S_SHIFT_X;
                    end
                end
            end
            S_QUERY: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (occ_vld_q) begin
                    if (!occ_hit_q) begin
                        state_d  = S_DONE;
                        food_x_d = cand_x_q;
                        food_y_d = cand_y_q;
                    end else if (scan_mode_q) begin
                        scan_cnt_d = scan_inc;
                        state_d    = (scan_inc == SCAN_LIMIT) ? S_FAIL : S_SCAN;
                    end else begin
                        try_cnt_d = try_inc;
                        if (try_inc == TRY_LIMIT) begin
                            state_d     = S_SCAN;
                            cand_x_d    = '0;
                            cand_y_d    = '0;
                            scan_mode_d = 1'b1;
                            scan_hold_d = 1'b1;
                        end else begin
                            state_d = S_SHIFT_X;
                        end
                    end
                end
            end
            S_SCAN: begin
                scan_hold_d = 1'b0;
                state_d     = S_QUERY;
                if (!scan_hold_q) begin
                    if (cand_x_q == X_LAST) begin
                        cand_x_d = '0;
                        cand_y_d = (cand_y_q == Y_LAST) ? '0 : cand_y_q + Y_BITS'(1);
                    end else begin
                        cand_x_d = cand_x_q + X_BITS'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.query_valid = (state_q == S_QUERY);
    assign bus.query_x     = cand_x_q;
    assign bus.query_y     = cand_y_q;
    assign bus.food_x      = food_x_q;
    assign bus.food_y      = food_y_q;
    assign bus.food_valid  = (state_q == S_DONE);
    assign bus.place_fail  = (state_q == S_FAIL);
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: doc/food_placer.md
Name: food_placer

Overview:
- Consumer end of the snake game's random-bit stream: takes the serial LFSR output, assembles candidate (x, y) food coordinates and range-checks them.
- Asks the snake-body occupancy responder whether each candidate cell is free, and retries until it finds a free cell.
- Sits between the LFSR and the game-control FSM. Control raises place_req after the snake eats; the block returns one food_valid pulse with the new coordinates, or one place_fail pulse if the board is full.

Parameters:
- GRID_W, 32, playfield width in cells.
- GRID_H, 24, playfield height in cells.
- X_BITS, 5, coordinate width for x; requires 2^X_BITS >= GRID_W.
- Y_BITS, 5, coordinate width for y; requires 2^Y_BITS >= GRID_H.
- MAX_TRIES, 16, number of random candidates rejected before switching to scan mode.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rand_bit  in  1  serial random bit from the LFSR; fresh value every cycle.
- place_req  in  1  request a new food position; sampled only in IDLE.
- query_valid  out  1  one-cycle strobe: occupancy lookup of query_x/query_y.
- query_x  out  X_BITS  candidate x; held stable from the strobe until occ_valid.
- query_y  out  Y_BITS  candidate y; held stable from the strobe until occ_valid.
- occ_valid  in  1  responder result strobe, at least 1 cycle after query_valid.
- occ_hit  in  1  qualified by occ_valid: 1 = cell occupied by snake.
- food_x  out  X_BITS  last placed food x; holds between placements.
- food_y  out  Y_BITS  last placed food y; holds between placements.
- food_valid  out  1  one-cycle pulse when food_x/food_y update.
- place_fail  out  1  one-cycle pulse: every cell occupied, no placement.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset state: FSM goes to IDLE. All outputs are 0, including food_x/food_y. try_cnt and scan_cnt are cleared.
- Reset mid-operation aborts the placement immediately. Any later occ_valid is ignored, because IDLE ignores occ_valid.
- States: IDLE, SHIFT_X, SHIFT_Y, RANGE, QUERY, WAIT, SCAN, DONE, FAIL.
- IDLE: if place_req=1 in cycle n, go to SHIFT_X. try_cnt=0, scan_cnt=0. place_req while busy is ignored and is not queued.
- SHIFT_X: X_BITS cycles. Each cycle, cand_x <= {cand_x[X_BITS-2:0], rand_bit}, so the first bit received ends up as the MSB.
- SHIFT_Y: Y_BITS cycles, same rule into cand_y.
- RANGE (1 cycle):
  - If cand_x < GRID_W and cand_y < GRID_H, go to QUERY.
  - Otherwise try_cnt++. If try_cnt reaches MAX_TRIES, go to SCAN with the candidate set to (0,0). Otherwise go back to SHIFT_X.
- QUERY (1 cycle): query_valid=1.
- WAIT: hold until occ_valid.
  - occ_hit=0: go to DONE.
  - occ_hit=1, random mode: try_cnt++. If try_cnt reaches MAX_TRIES, go to SCAN. Otherwise go to SHIFT_X.
  - occ_hit=1, scan mode: scan_cnt++. If scan_cnt = GRID_W*GRID_H, go to FAIL. Otherwise go to SCAN.
- SCAN (1 cycle): advance the candidate row-major.
  - x++. If x was GRID_W-1, x=0 and y++. If y was GRID_H-1 as well, y=0.
  - Then go to QUERY.
  - The first entry into SCAN from RANGE uses (0,0) unadvanced, so (0,0) is queried first.
- DONE (1 cycle): food_x/food_y <= candidate, food_valid=1, then IDLE.
- FAIL (1 cycle): place_fail=1, then IDLE; food_x/food_y unchanged.
- Nominal latency: req at cycle n gives query_valid at n+1+X_BITS+Y_BITS+1 = n+12 with defaults. food_valid is 2 cycles after occ_valid.
- Counters:
  - try_cnt is clog2(MAX_TRIES+1) bits.
  - scan_cnt is clog2(GRID_W*GRID_H+1) bits.
  - All comparisons are unsigned.
- occ_valid outside WAIT is ignored. The responder must not respond twice to one query.

Test Plan:
- Free cell. Defaults; place_req at cycle 0; rand_bit stream 0,0,0,1,1 then 0,0,1,0,1. Required: query_valid at cycle 12 with query_x=3, query_y=5. occ_valid with occ_hit=0 at cycle 14 gives food_valid at cycle 16 with food_x=3, food_y=5; busy falls at cycle 17.
- Out of range. y bits 1,1,0,0,0 (y=24). Required: no query_valid, new shift begins; the next valid candidate (x=7, y=2) is queried; try_cnt=1 before that query.
- Collision retry. First candidate (3,5) answered occ_hit=1, second (10,10) answered free. Required: exactly two query_valid strobes and food at (10,10).
- Scan fallback. Force 16 consecutive hits, MAX_TRIES=16. Responder marks (0,0) and (1,0) occupied. Required: scan queries (0,0), (1,0), (2,0); food at (2,0).
- Full board. Responder always returns occ_hit=1. Required: after 16 random tries plus 768 scan queries, exactly one place_fail pulse, food_x/food_y unchanged, no food_valid, return to IDLE.
- Reset and ignored requests. Assert reset during WAIT; deliver occ_valid one cycle after reset releases. Required: busy=0, no food_valid, all outputs 0. Separately, place_req pulsed while busy causes no second placement.
